// File: rtl/cu_data_read_engine_control.sv
// Read engine control: walks a job descriptor into cacheline read commands under a credit limit.
// Optional stall counter port/logic is built when CU_READ_ENGINE_STALL_COUNTER_EN is defined.
module cu_data_read_engine_control #(
  parameter int CACHELINE_BYTES = 128,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_BITS        = 8,
  parameter int ARRAY_SIZE_BITS = 32
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         enabled_in,
  input  logic                         wed_valid_in,
  input  logic [63:0]                  wed_base_addr_in,
  input  logic [ARRAY_SIZE_BITS-1:0]   wed_size_lines_in,
  input  logic                         read_buffer_full_in,
  output logic                         read_cmd_valid_out,
  output logic [63:0]                  read_cmd_addr_out,
  output logic [TAG_BITS-1:0]          read_cmd_tag_out,
  input  logic                         read_resp_valid_in,
  input  logic                         read_resp_error_in,
  input  logic                         read_data_valid_in,
  input  logic [CACHELINE_BYTES*8-1:0] read_data_in,
  output logic                         data_valid_out,
  output logic [CACHELINE_BYTES*8-1:0] data_out,
  output logic [ARRAY_SIZE_BITS-1:0]   read_job_counter_done,
  output logic                         job_done_out,
  output logic                         error_out
`ifdef CU_READ_ENGINE_STALL_COUNTER_EN
  ,
  output logic [31:0]                  read_stall_count_out
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int ASB   = ARRAY_SIZE_BITS;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                       r_state, w_next;
  logic [63:0]                  r_base;
  logic [ASB-1:0]               r_size;
  logic [ASB-1:0]               r_issued;
  logic [ASB-1:0]               r_done_cnt;
  logic [OUT_W-1:0]             r_out;
  logic                         r_pend;
  logic                         r_cmd_valid;
  logic [63:0]                  r_cmd_addr;
  logic [TAG_BITS-1:0]          r_cmd_tag;
  logic                         r_data_valid;
  logic [CACHELINE_BYTES*8-1:0] r_data;
  logic                         r_job_done;
  logic                         r_err;

  logic w_wed_take, w_issue, w_accept, w_last, w_blocked;

  // A descriptor is only taken where a job may start; elsewhere it is dropped.
  assign w_wed_take = enabled_in && wed_valid_in && (r_state == S_IDLE || r_state == S_DONE);
  assign w_blocked  = (r_state == S_ISSUE) && enabled_in && (r_issued < r_size) &&
                      (read_buffer_full_in || (r_out >= OUT_W'(MAX_OUTSTANDING)));
  assign w_issue    = (r_state == S_ISSUE) && enabled_in && !read_buffer_full_in &&
                      (r_out < OUT_W'(MAX_OUTSTANDING)) && (r_issued < r_size);
  assign w_accept   = read_resp_valid_in && (r_out != '0);
  assign w_last     = w_issue && ((r_issued + ASB'(1)) == r_size);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_pend || (enabled_in && wed_valid_in)) w_next = S_SETUP;
      S_SETUP: w_next = (r_size == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_out == '0 && r_done_cnt == r_size) w_next = S_DONE;
      S_DONE:  if (!enabled_in || wed_valid_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_size       <= '0;
      r_issued     <= '0;
      r_done_cnt   <= '0;
      r_out        <= '0;
      r_pend       <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_tag    <= '0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_job_done   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wed_take) begin
        r_base <= wed_base_addr_in;
        r_size <= wed_size_lines_in;
      end
      // A job taken from DONE waits one cycle in IDLE before its SETUP.
      r_pend <= (r_state == S_DONE) && w_wed_take;

      if (w_next == S_SETUP) begin
        r_issued   <= '0;
        r_done_cnt <= '0;
        r_out      <= '0;
        r_err      <= 1'b0;
        r_job_done <= 1'b0;
      end else begin
        r_issued <= r_issued + ASB'(w_issue);
        case ({w_issue, w_accept})
          2'b10:   r_out <= r_out + OUT_W'(1);
          2'b01:   r_out <= r_out - OUT_W'(1);
          default: r_out <= r_out;
        endcase
        if (w_accept && r_done_cnt < r_size) r_done_cnt <= r_done_cnt + ASB'(1);
        if (w_accept && read_resp_error_in)  r_err <= 1'b1;
        if (w_next == S_DONE)                r_job_done <= 1'b1;
      end

      r_cmd_valid <= w_issue;
      if (w_issue) begin
        r_cmd_addr <= r_base + (64'(r_issued) * 64'(CACHELINE_BYTES));
        r_cmd_tag  <= TAG_BITS'(r_issued);
      end

      r_data_valid <= read_data_valid_in && (r_state != S_IDLE);
      r_data       <= (r_state != S_IDLE) ? read_data_in : '0;
    end
  end

`ifdef CU_READ_ENGINE_STALL_COUNTER_EN
  logic [31:0] r_stall;
  always_ff @(posedge clock) begin
    if (rst || w_next == S_SETUP) r_stall <= '0;
    else if (w_blocked && r_stall != 32'hFFFF_FFFF) r_stall <= r_stall + 32'd1;
  end
  assign read_stall_count_out = r_stall;
`else
  logic w_unused_blocked;
  assign w_unused_blocked = w_blocked;
`endif

  assign read_cmd_valid_out    = r_cmd_valid;
  assign read_cmd_addr_out     = r_cmd_addr;
  assign read_cmd_tag_out      = r_cmd_tag;
  assign data_valid_out        = r_data_valid;
  assign data_out              = r_data;
  assign read_job_counter_done = r_done_cnt;
  assign job_done_out          = r_job_done;
  assign error_out             = r_err;

endmodule

// File: tb/tb_cu_data_read_engine_control.sv
// Directed + randomized bench for cu_data_read_engine_control with a transaction-level reference.
module tb_cu_data_read_engine_control;
  localparam int CL = 128;
  localparam int DW = CL * 8;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, wed_v = 1'b0, full = 1'b0;
  logic [63:0]   wed_a = '0;
  logic [31:0]   wed_s = '0;
  logic          resp_v = 1'b0, resp_e = 1'b0, dat_v = 1'b0;
  logic [DW-1:0] dat = '0;
  logic          cmd_v, dvo, jdone, err;
  logic [63:0]   cmd_a;
  logic [7:0]    cmd_t;
  logic [DW-1:0] dout;
  logic [31:0]   cnt;
`ifdef CU_READ_ENGINE_STALL_COUNTER_EN
  logic [31:0]   stall;
`endif

  cu_data_read_engine_control dut (
    .clock(clock), .rst(rst), .enabled_in(en), .wed_valid_in(wed_v),
    .wed_base_addr_in(wed_a), .wed_size_lines_in(wed_s), .read_buffer_full_in(full),
    .read_cmd_valid_out(cmd_v), .read_cmd_addr_out(cmd_a), .read_cmd_tag_out(cmd_t),
    .read_resp_valid_in(resp_v), .read_resp_error_in(resp_e),
    .read_data_valid_in(dat_v), .read_data_in(dat),
    .data_valid_out(dvo), .data_out(dout), .read_job_counter_done(cnt),
    .job_done_out(jdone), .error_out(err)
`ifdef CU_READ_ENGINE_STALL_COUNTER_EN
    , .read_stall_count_out(stall)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  // Reference: the job is a list of lines base+k*CL; commands must appear in order,
  // only after a cycle with enable high and buffer not full, never more than 16 unanswered.
  logic [63:0] m_base;
  int          m_size, m_cmds, m_resp;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic pf, pe;
    pf = full;
    pe = en;
    @(posedge clock); #1;
    if (cmd_v) begin
      chk("cmd_addr", cmd_a, m_base + 64'(m_cmds) * 64'(CL));
      chk("cmd_tag", 64'(cmd_t), 64'(m_cmds % 256));
      chk("cmd_gate", 64'({pf, pe}), 64'(2'b01));
      m_cmds++;
      chk("credit", 64'((m_cmds - m_resp) <= 16), 1);
      chk("cmd_overrun", 64'(m_cmds <= m_size), 1);
    end
  endtask

  task automatic start_job(input logic [63:0] b, input int s);
    m_base = b; m_size = s; m_cmds = 0; m_resp = 0; m_err = 1'b0;
    en = 1'b1; wed_v = 1'b1; wed_a = b; wed_s = 32'(s);
    cyc();
    wed_v = 1'b0;
  endtask

  task automatic wait_cmds(input int n, input int budget);
    int k = 0;
    while (m_cmds < n && k < budget) begin cyc(); k++; end
    chk("cmd_wait", 64'(m_cmds >= n), 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!jdone && k < budget) begin cyc(); k++; end
    chk("done_wait", 64'(jdone), 1);
  endtask

  // Answers every outstanding command; with rnd, also throttles, toggles enable and fires stray descriptors.
  task automatic run_job(input bit rnd, input int budget);
    int k = 0;
    while (m_resp < m_size && k < budget) begin
      wed_v = 1'b0;
      if (rnd) begin
        full = ($urandom % 4) == 0;
        en   = ($urandom % 8) != 0;
        if (m_cmds >= 1 && m_cmds < m_size && ($urandom % 16) == 0) begin
          wed_v = 1'b1; wed_a = 64'hDEAD_0000; wed_s = 32'd3;
        end
      end
      if (m_cmds > m_resp && (!rnd || ($urandom % 2) == 0)) begin
        resp_v = 1'b1;
        resp_e = rnd && (($urandom % 10) == 0);
        m_err  = m_err | resp_e;
        m_resp++;
      end else begin
        resp_v = 1'b0; resp_e = 1'b0;
      end
      cyc(); k++;
    end
    resp_v = 1'b0; resp_e = 1'b0; full = 1'b0; en = 1'b1; wed_v = 1'b0;
    chk("job_budget", 64'(m_resp >= m_size), 1);
    wait_done(60);
    chk("job_count", 64'(cnt), 64'(m_size));
    chk("job_err", 64'(err), 64'(m_err));
    chk("job_cmds", 64'(m_cmds), 64'(m_size));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic [63:0]   b;
    m_base = '0; m_size = 0; m_cmds = 0; m_resp = 0; m_err = 1'b0;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_cmd_v", 64'(cmd_v), 0);
    chk("rst_cmd_a", cmd_a, 0);
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_done", 64'(jdone), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_dv", 64'(dvo), 0);

    // Basic job: four back-to-back commands, then data forward and four responses
    start_job(64'h1000, 4);
    wait_cmds(1, 6);
    repeat (3) begin cyc(); chk("basic_b2b", 64'(cmd_v), 1); end
    cyc();
    chk("basic_ncmd", 64'(m_cmds), 4);
    chk("basic_stop", 64'(cmd_v), 0);
    d = {$urandom, $urandom, $urandom, $urandom};
    d[DW-1 -: 32] = $urandom;
    dat = d; dat_v = 1'b1;
    cyc();
    dat_v = 1'b0;
    chk("data_v", 64'(dvo), 1);
    chk("data_lo", dout[63:0], d[63:0]);
    chk("data_eq", 64'(dout === d), 1);
    cyc();
    chk("data_v_off", 64'(dvo), 0);
    run_job(1'b0, 20);

    // Zero size from IDLE: DONE two cycles after the descriptor, no command
    en = 1'b0; cyc();
    chk("done_sticky", 64'(jdone), 1);
    start_job(64'h2000, 0);
    chk("zero_clr", 64'(jdone), 0);
    cyc();
    chk("zero_done", 64'(jdone), 1);
    chk("zero_cmd", 64'(m_cmds), 0);
    chk("zero_cnt", 64'(cnt), 0);

    // Error response in the same cycle as an issue
    start_job(64'h4_0000, 8);
    wait_cmds(1, 6);
    resp_v = 1'b1; resp_e = 1'b1; m_resp++; m_err = 1'b1;
    cyc();
    resp_v = 1'b0; resp_e = 1'b0;
    chk("simul_issue", 64'(cmd_v), 1);
    chk("simul_cnt", 64'(cnt), 1);
    chk("simul_err", 64'(err), 1);
    run_job(1'b0, 40);

    // Backpressure: five full cycles, no issue while full; error cleared by new job
    start_job(64'h8_0000, 10);
    wait_cmds(1, 6);
    chk("err_cleared", 64'(err), 0);
    full = 1'b1;
    repeat (5) begin cyc(); chk("bp_noissue", 64'(cmd_v), 0); end
    full = 1'b0;
    cyc();
    chk("bp_resume", 64'(cmd_v), 1);
    wait_cmds(10, 20);
`ifdef CU_READ_ENGINE_STALL_COUNTER_EN
    chk("stall_count", 64'(stall), 5);
`endif
    run_job(1'b0, 40);

    // Credit limit: 16 in flight, then one command per response
    start_job(64'h10_0000, 20);
    repeat (25) cyc();
    chk("credit_16", 64'(m_cmds), 16);
    for (int r = 0; r < 4; r++) begin
      resp_v = 1'b1; m_resp++;
      cyc();
      resp_v = 1'b0;
      repeat (3) cyc();
      chk("credit_step", 64'(m_cmds), 64'(17 + r));
    end
    run_job(1'b0, 60);

    // Randomized jobs, each started straight from DONE
    for (int j = 0; j < 6; j++) begin
      b = {32'($urandom), 32'($urandom)} & 64'h7FFF_FFFF_FFFF_FF80;
      start_job(b, int'($urandom_range(40, 1)));
      run_job(1'b1, 1000);
    end

    // Reset in DRAIN with three outstanding
    start_job(64'h20_0000, 3);
    wait_cmds(3, 10);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_cmd_v", 64'(cmd_v), 0);
    chk("mid_cmd_a", cmd_a, 0);
    chk("mid_tag", 64'(cmd_t), 0);
    chk("mid_cnt", 64'(cnt), 0);
    chk("mid_done", 64'(jdone), 0);
    chk("mid_dv", 64'(dvo), 0);
    resp_v = 1'b1; resp_e = 1'b1;
    repeat (3) cyc();
    resp_v = 1'b0; resp_e = 1'b0;
    chk("late_cnt", 64'(cnt), 0);
    chk("late_err", 64'(err), 0);
    chk("late_done", 64'(jdone), 0);

    // Data in IDLE is dropped
    dat = '1; dat_v = 1'b1;
    cyc();
    dat_v = 1'b0;
    chk("idle_drop_v", 64'(dvo), 0);
    chk("idle_drop_d", dout[63:0], 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
